// File: rtl/sd_pkg.sv
// Shared types and constants for the radix-2 signed-digit online adder.
// A digit is a (p, m) bit pair whose value is p - m.
package sd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } sd_state_t;

    typedef struct packed {
        logic p;
        logic m;
    } sd_digit_t;

    // Carry/sum values that stand in for the digit after the frame end.
    localparam logic G_END = 1'b1;
    localparam logic E_END = 1'b0;

    // Returns {carry, sum} of a one-bit full add.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/sd_online_lane.sv
// One lane of the online adder: two full-add stages with their delay registers.
// The top level decides when each stage advances and which output digit to form.
module sd_online_lane
    import sd_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load,
    input  logic      sub,
    input  logic      stage2_en,
    input  logic      flush_end,
    input  logic      out_en,
    input  logic      out_z0,
    input  logic      out_final,
    input  sd_digit_t x,
    input  sd_digit_t y,
    output sd_digit_t z
);

    logic      yp_eff;
    logic      ym_eff;
    logic      g_cur;
    logic      h_cur;
    logic      g_in;
    logic      e_cur;
    logic      f_cur;
    logic      g_r;
    logic      h_r;
    logic      ym_r;
    logic      f_r;
    sd_digit_t z_next;

    // Stage 1 works on the incoming digit; stage 2 finishes the previous digit
    // using the newest carry g, or the frame-end carry while flushing.
    always_comb begin
        yp_eff         = sub ? y.m : y.p;
        ym_eff         = sub ? y.p : y.m;
        {g_cur, h_cur} = full_add(x.p, ~x.m, yp_eff);
        g_in           = flush_end ? G_END : g_cur;
        {e_cur, f_cur} = full_add(h_r, ~ym_r, g_in);
        z_next.p       = f_r;
        z_next.m       = ~e_cur;
        if (out_z0) begin
            z_next.p = e_cur;
            z_next.m = ~g_r;
        end else if (out_final) begin
            z_next.p = f_r;
            z_next.m = ~E_END;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_r  <= 1'b0;
            h_r  <= 1'b0;
            ym_r <= 1'b0;
            f_r  <= 1'b0;
            z    <= '0;
        end else begin
            if (load) begin
                g_r  <= g_cur;
                h_r  <= h_cur;
                ym_r <= ym_eff;
            end
            if (stage2_en) begin
                f_r <= f_cur;
            end
            if (out_en) begin
                z <= z_next;
            end
        end
    end

endmodule

// File: rtl/sd_online_serial_adder.sv
// MSD-first online signed-digit adder/subtractor, LANES lanes under one control path.
// Each NDIG-digit frame yields NDIG+1 result digits with an online delay of 2.
module sd_online_serial_adder
    import sd_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [LANES-1:0] x_p,
    input  logic [LANES-1:0] x_m,
    input  logic [LANES-1:0] y_p,
    input  logic [LANES-1:0] y_m,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [LANES-1:0] z_p,
    output logic [LANES-1:0] z_m,
    output logic             busy
);

    localparam int CW = $clog2(NDIG + 1);

    sd_state_t     state;
    logic [CW-1:0] cnt;
    logic          sub_r;
    logic          accept;
    logic          first_digit;
    logic          sub_eff;
    logic          stage2_en;
    logic          flush_end;
    logic          out_z0;
    logic          out_final;
    logic          out_en;

    // cnt holds the number of digits already accepted in this frame, so a
    // zero count marks the incoming digit as digit 1.
    always_comb begin
        in_ready    = (state == IDLE) || (state == RUN);
        busy        = (state != IDLE);
        accept      = in_valid && in_ready;
        first_digit = (cnt == '0);
        sub_eff     = first_digit ? in_sub : sub_r;
        flush_end   = (state == FLUSH1);
        out_final   = (state == FLUSH2);
        stage2_en   = (accept && !first_digit) || flush_end;
        out_z0      = accept && (cnt == CW'(1));
        out_en      = stage2_en || out_final;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sub_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        cnt   <= CW'(1);
                        sub_r <= in_sub;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NDIG - 1)) begin
                            state <= FLUSH1;
                        end
                    end
                end
                FLUSH1: state <= FLUSH2;
                FLUSH2: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= out_en;
            out_first <= out_z0;
            out_last  <= out_final;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sd_digit_t x_d;
        sd_digit_t y_d;
        sd_digit_t z_d;

        assign x_d.p = x_p[i];
        assign x_d.m = x_m[i];
        assign y_d.p = y_p[i];
        assign y_d.m = y_m[i];

        sd_online_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (accept),
            .sub       (sub_eff),
            .stage2_en (stage2_en),
            .flush_end (flush_end),
            .out_en    (out_en),
            .out_z0    (out_z0),
            .out_final (out_final),
            .x         (x_d),
            .y         (y_d),
            .z         (z_d)
        );

        assign z_p[i] = z_d.p;
        assign z_m[i] = z_d.m;
    end

endmodule

// File: tb/tb_sd_online_serial_adder.sv
// Directed-vector bench for the online adder: a 4-digit single-lane instance for
// hand-computed frames and corner cases, and an 8-digit 4-lane instance for random frames.
module tb_sd_online_serial_adder;

    localparam int NA = 4;
    localparam int NB = 8;
    localparam int LB = 4;
    localparam int NV = 10;
    localparam int NFRAMES_B = 1000;

    typedef struct {
        logic [NA-1:0] xp;
        logic [NA-1:0] xm;
        logic [NA-1:0] yp;
        logic [NA-1:0] ym;
        logic          sub;
        int            exp_units;
    } vec_t;

    typedef struct {
        int value;
        int digits;
        int z0;
        int low;
        int first_edge;
        int last_edge;
    } res_t;

    typedef struct {
        int v[LB];
    } lane_vals_t;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_no = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no <= edge_no + 1;

    logic          a_in_valid, a_in_ready, a_in_sub;
    logic [0:0]    a_x_p, a_x_m, a_y_p, a_y_m, a_z_p, a_z_m;
    logic          a_out_valid, a_out_first, a_out_last, a_busy;

    logic          b_in_valid, b_in_ready, b_in_sub;
    logic [LB-1:0] b_x_p, b_x_m, b_y_p, b_y_m, b_z_p, b_z_m;
    logic          b_out_valid, b_out_first, b_out_last, b_busy;

    sd_online_serial_adder #(.NDIG(NA), .LANES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sub(a_in_sub), .x_p(a_x_p), .x_m(a_x_m), .y_p(a_y_p), .y_m(a_y_m),
        .out_valid(a_out_valid), .out_first(a_out_first), .out_last(a_out_last),
        .z_p(a_z_p), .z_m(a_z_m), .busy(a_busy)
    );

    sd_online_serial_adder #(.NDIG(NB), .LANES(LB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sub(b_in_sub), .x_p(b_x_p), .x_m(b_x_m), .y_p(b_y_p), .y_m(b_y_m),
        .out_valid(b_out_valid), .out_first(b_out_first), .out_last(b_out_last),
        .z_p(b_z_p), .z_m(b_z_m), .busy(b_busy)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor for the 4-digit instance: rebuilds each frame's value in units of 2^-NA.
    res_t a_res[$];
    res_t a_cur;
    bit   a_in_frame = 1'b0;
    int   a_first_cnt = 0, a_last_cnt = 0, a_valid_cnt = 0, a_dv;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_in_frame = 1'b0;
        end else if (a_out_valid) begin
            a_valid_cnt++;
            if (a_out_first) begin
                a_first_cnt++;
                a_in_frame = 1'b1;
                a_cur = '{0, 0, 0, 0, edge_no, 0};
            end
            if (a_in_frame) begin
                a_dv = int'(a_z_p[0]) - int'(a_z_m[0]);
                if (a_cur.digits == 0) a_cur.z0 = a_dv;
                if (a_cur.digits <= NA) a_cur.value += a_dv * (1 << (NA - a_cur.digits));
                a_cur.digits++;
            end
            if (a_out_last) begin
                a_last_cnt++;
                if (a_in_frame) begin
                    a_cur.last_edge = edge_no;
                    a_res.push_back(a_cur);
                end
                a_in_frame = 1'b0;
            end
        end else if (a_in_frame) begin
            a_cur.low++;
        end
    end

    // Monitor for the 4-lane instance: compares each finished frame against the queued model.
    lane_vals_t b_exp[$];
    lane_vals_t b_e;
    int  b_acc[LB];
    int  b_k = 0, b_first_cnt = 0, b_last_cnt = 0;
    bit  b_in_frame = 1'b0;

    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (b_out_first) begin
                b_first_cnt++;
                b_in_frame = 1'b1;
                b_k = 0;
                for (int l = 0; l < LB; l++) b_acc[l] = 0;
            end
            if (b_in_frame && b_k <= NB) begin
                for (int l = 0; l < LB; l++)
                    b_acc[l] += (int'(b_z_p[l]) - int'(b_z_m[l])) * (1 << (NB - b_k));
            end
            b_k++;
            if (b_out_last) begin
                b_last_cnt++;
                b_in_frame = 1'b0;
                if (b_exp.size() > 0) begin
                    b_e = b_exp.pop_front();
                    for (int l = 0; l < LB; l++)
                        check_output($sformatf("lane%0d_value", l), b_acc[l], b_e.v[l]);
                end else begin
                    check_output("b_unexpected_last", b_exp.size(), 1);
                end
            end
        end
    end

    task automatic drive_a(input logic xp, input logic xm, input logic yp, input logic ym,
                           input logic sub, output int acc_edge);
        int waited = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_x_p[0] = xp; a_x_m[0] = xm; a_y_p[0] = yp; a_y_m[0] = ym;
        a_in_sub = sub;
        while (!a_in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!a_in_ready) check_output("a_in_ready_wait", int'(a_in_ready), 1);
        @(posedge clk);
        #1;
        acc_edge = edge_no;
        a_in_valid = 1'b0;
    endtask

    // Drives one frame; in_sub carries the frame's mode on digit 1 and the opposite afterwards.
    task automatic apply_stimulus(input vec_t v, input int gap,
                                  output int d1, output int d2, output int dn);
        int   e;
        logic s;
        d1 = 0; d2 = 0; dn = 0;
        for (int j = 1; j <= NA; j++) begin
            s = (j == 1) ? v.sub : ~v.sub;
            drive_a(v.xp[NA-j], v.xm[NA-j], v.yp[NA-j], v.ym[NA-j], s, e);
            if (j == 1) d1 = e;
            if (j == 2) d2 = e;
            if (j == NA) dn = e;
            if (j == 2) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic collect_a(input string name, input int exp_units, input int exp_low,
                             output res_t r);
        int n = 0;
        r = '{0, 0, 0, 0, 0, 0};
        while (a_res.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_done"}, (a_res.size() > 0) ? 1 : 0, 1);
        if (a_res.size() > 0) begin
            r = a_res.pop_front();
            check_output({name, "_value"}, r.value, exp_units);
            check_output({name, "_digits"}, r.digits, NA + 1);
            check_output({name, "_gap_cycles"}, r.low, exp_low);
        end
    endtask

    task automatic drive_b(input logic [LB-1:0] xp, input logic [LB-1:0] xm,
                           input logic [LB-1:0] yp, input logic [LB-1:0] ym, input logic sub);
        int waited = 0;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_x_p = xp; b_x_m = xm; b_y_p = yp; b_y_m = ym;
        b_in_sub = sub;
        while (!b_in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!b_in_ready) check_output("b_in_ready_wait", int'(b_in_ready), 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        vec_t vecs[NV];
        res_t r, r2;
        int   d1, d2, dn, n1, n2, nn, vc, a_frames;
        logic [LB-1:0] xp[NB], xm[NB], yp[NB], ym[NB];
        lane_vals_t ev;
        int   xv[LB], yv[LB];
        logic fsub;

        vecs[0] = '{4'b1011, 4'b0000, 4'b0101, 4'b0000, 1'b0,  16};
        vecs[1] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b0, -30};
        vecs[2] = '{4'b1011, 4'b0000, 4'b0101, 4'b0000, 1'b1,   6};
        vecs[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1,  30};
        vecs[4] = '{4'b1111, 4'b1111, 4'b1000, 4'b0000, 1'b0,   8};
        vecs[5] = '{4'b1001, 4'b0100, 4'b0010, 4'b1001, 1'b0,  -2};
        vecs[6] = '{4'b1001, 4'b0100, 4'b0010, 4'b1001, 1'b1,  12};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0,   0};
        vecs[8] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b0,  30};
        vecs[9] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1,   2};
        a_frames = 0;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_sub = 1'b0;
        a_x_p = '0; a_x_m = '0; a_y_p = '0; a_y_m = '0;
        b_in_valid = 1'b0; b_in_sub = 1'b0;
        b_x_p = '0; b_x_m = '0; b_y_p = '0; b_y_m = '0;
        #1;
        check_output("reset_in_ready", int'(a_in_ready), 1);
        check_output("reset_outputs", int'({a_out_valid, a_out_first, a_out_last, a_z_p, a_z_m, a_busy}), 0);
        check_output("reset_outputs_b", int'({b_out_valid, b_out_first, b_out_last, b_z_p, b_z_m, b_busy}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released, running directed table");

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i], 0, d1, d2, dn);
            a_frames++;
            collect_a($sformatf("vec%0d", i), vecs[i].exp_units, 0, r);
        end

        // Output framing latency for a back-to-back frame.
        apply_stimulus(vecs[0], 0, d1, d2, dn);
        a_frames++;
        collect_a("timing", 16, 0, r);
        check_output("first_edge", r.first_edge - d2, 0);
        check_output("last_edge", r.last_edge - d1, 5);

        // Extreme negatives, then a second frame pushed as early as the block allows.
        apply_stimulus(vecs[1], 0, d1, d2, dn);
        apply_stimulus(vecs[0], 0, n1, n2, nn);
        a_frames += 2;
        check_output("next_frame_edge", n1 - dn, 3);
        collect_a("neg", -30, 0, r);
        check_output("neg_z0", r.z0, -1);
        collect_a("after_neg", 16, 0, r2);

        // Three-cycle input gap between digits 2 and 3.
        apply_stimulus(vecs[0], 3, d1, d2, dn);
        a_frames++;
        collect_a("gap", 16, 3, r);

        // Reset pulse after digit 3 of a frame.
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d1);
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d1);
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d1);
        @(negedge clk);
        check_output("busy_mid_frame", int'(a_busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("midreset_in_ready", int'(a_in_ready), 1);
        check_output("midreset_outputs", int'({a_out_valid, a_out_first, a_out_last, a_z_p, a_z_m, a_busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vc = a_valid_cnt;
        repeat (8) @(negedge clk);
        check_output("midreset_no_valid", a_valid_cnt - vc, 0);
        check_output("midreset_idle", int'(a_busy), 0);
        apply_stimulus(vecs[0], 0, d1, d2, dn);
        a_frames++;
        collect_a("after_reset", 16, 0, r);
        check_output("a_last_count", a_last_cnt, a_frames);
        check_output("a_first_count", a_first_cnt, a_frames + 1);

        $display("[TB] running %0d random frames on the 4-lane instance", NFRAMES_B);
        for (int f = 0; f < NFRAMES_B; f++) begin
            fsub = 1'($urandom_range(0, 1));
            for (int l = 0; l < LB; l++) begin
                xv[l] = 0;
                yv[l] = 0;
            end
            for (int j = 1; j <= NB; j++) begin
                xp[j-1] = LB'($urandom); xm[j-1] = LB'($urandom);
                yp[j-1] = LB'($urandom); ym[j-1] = LB'($urandom);
                for (int l = 0; l < LB; l++) begin
                    xv[l] += (int'(xp[j-1][l]) - int'(xm[j-1][l])) * (1 << (NB - j));
                    yv[l] += (int'(yp[j-1][l]) - int'(ym[j-1][l])) * (1 << (NB - j));
                end
            end
            for (int l = 0; l < LB; l++) ev.v[l] = fsub ? (xv[l] - yv[l]) : (xv[l] + yv[l]);
            b_exp.push_back(ev);
            for (int j = 1; j <= NB; j++) begin
                drive_b(xp[j-1], xm[j-1], yp[j-1], ym[j-1],
                        (j == 1) ? fsub : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check_output("b_first_count", b_first_cnt, NFRAMES_B);
        check_output("b_last_count", b_last_cnt, NFRAMES_B);
        check_output("b_pending", b_exp.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sd_online_serial_adder.md
# sd_online_serial_adder

- Digit-serial, MSD-first online adder/subtractor for radix-2 signed-digit (plus/minus bit-pair) operands.
- Runs LANES independent lanes under one shared control path, with online delay 2 and a frame length of NDIG digits.
- Emits NDIG+1 result digits per frame.
- Sits between the digit-serial operand sources and downstream online units.

## Interface
- NDIG, 8, digits per input operand frame (≥ 2)
- LANES, 1, independent lanes sharing control
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  digit j of every lane present
- in_ready  out  1  block accepts a digit this cycle
- in_sub  in  1  sampled with digit 1 only; 1 = compute X − Y for the whole frame
- x_p, x_m, y_p, y_m  in  LANES  per-lane digit pairs; digit value = p − m
- out_valid  out  1  z_p/z_m hold a result digit
- out_first  out  1  with out_valid, marks digit z_0
- out_last  out  1  with out_valid, marks digit z_NDIG
- z_p, z_m  out  LANES  result digit pairs
- busy  out  1  frame in progress (state ≠ IDLE)

## Operation
- **Value definition:** X = Σ_{j=1..NDIG} x_j·2^-j; Y is defined the same way; Z = Σ_{k=0..NDIG} z_k·2^-k.
- **Result requirement:** Z = X ± Y exactly, per lane.
- **Encodings:** (1,1) is legal on both inputs and outputs and means 0. Checkers compare values, never encodings.
- **Subtract:** in_sub is latched at digit 1. When it is 1, y_p and y_m are swapped for every digit of the frame.
- **Stage 1, per digit j:** full add of (x_p, ~x_m, y_p) gives carry g_j and sum h_j.
- **Stage 2, per digit j:** full add of (h_j, ~y_m, g_{j+1}) gives carry e_j and sum f_j.
- **Output digits:**
  - z_p_k = f_k and z_m_k = ~e_{k+1}, for k ≥ 1.
  - z_p_0 = e_1 and z_m_0 = ~g_1.
- **Frame-end constants:** g_{NDIG+1} = 1 and e_{NDIG+1} = 0.
- **Digit counter:** counts 1..NDIG. There is no in_last; the frame ends when the counter reaches NDIG.
- **FSM states:**
  - IDLE: in_ready = 1; an accepted digit goes to RUN.
  - RUN: in_ready = 1; acceptance of digit NDIG goes to FLUSH1.
  - FLUSH1: in_ready = 0; goes to FLUSH2.
  - FLUSH2: in_ready = 0; goes to IDLE.
- **Input gaps:** in_valid low in RUN freezes all pipeline state and drives out_valid low.

## Timing
- **Reset values:** every output is 0 except in_ready = 1. State = IDLE, counter = 0, pipeline registers = 0.
- **Reset mid-frame:** the partial frame is discarded and no further out_valid is produced. The next accepted digit is treated as digit 1.
- **Latency:** z_k is valid in the cycle after acceptance of digit k+2, for k = 0..NDIG-2.
- **Flush:** z_{NDIG-1} is emitted in FLUSH1 and z_NDIG in FLUSH2. Both use the frame-end constants.
- **Minimum frame period:** NDIG+2 cycles. Digit 1 of the next frame is accepted no earlier than the cycle after FLUSH2, when state is IDLE.
- **Output pacing:** out_valid is never asserted in two cycles unless the corresponding input was accepted, or the block is flushing. There is no output backpressure.
- **Output hold:** z_p/z_m hold their last value while out_valid = 0.
- **in_sub:** ignored on every digit except digit 1.
- **Result range:** |Z| ≤ 2 − 2^-NDIG·2. No overflow is possible, and z_0 ∈ {−1, 0, 1}.

## Structure
- **Shared package sd_pkg:**
  - state enum {IDLE, RUN, FLUSH1, FLUSH2}
  - signed-digit pair typedef
  - frame-end constants G_END = 1 and E_END = 0
- **Sub-module sd_online_lane:**
  - one lane: both full-add stages, g/h/e/f delay registers, and digit-pair output
  - instantiated LANES times
- **Top level:** FSM, counter, in_sub latch, and out_first/out_last generation.

## Test plan
1. **Basic add** (NDIG=4, LANES=1): x = (1,0,1,1) = 11/16, y = (0,1,0,1) = 5/16, back-to-back.
   - Expect 5 digits with value 1.
   - out_first one cycle after digit 2; out_last 6 cycles after digit 1.
2. **Extreme negatives:** all x = y = −1, in_sub = 0.
   - Expect Z = −30/16 with z_0 = −1.
   - Next frame accepted in the cycle after FLUSH2.
3. **Subtract:** in_sub = 1 at digit 1 and 0 thereafter, x = 11/16, y = 5/16.
   - Expect Z = 6/16.
4. **Input gaps:** in_valid low for 3 cycles between digits 2 and 3.
   - out_valid is low for exactly 3 cycles; Z is unchanged versus scenario 1.
5. **Reset mid-frame:** rst_n pulsed low after digit 3.
   - All outputs are 0 and state is IDLE; the next frame computes correctly from digit 1.
6. **Multi-lane random** (LANES=4, NDIG=8): 1000 random frames, random in_sub, random gaps.
   - Every lane's Z matches X ± Y.
   - Exactly one out_first and one out_last per frame.
